// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle controller sitting in front of shifter32.
// It turns one variable-amount shift request into a LOAD followed by N
// single-bit shift ops, then captures shifter32's output as the result.
// It also reports a done pulse and, for the reserved type, an err flag.

module shift_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       shift_type,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  output logic [2:0]       sh_op,
  output logic [WIDTH-1:0] sh_d_in,
  input  logic [WIDTH-1:0] sh_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned TYPE_W = 2;

  // shifter32 op encoding
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LOAD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LSL  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LSR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ASR  = OP_W'(4);

  // request shift types
  localparam logic [TYPE_W-1:0] TYPE_LSL = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] TYPE_LSR = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] TYPE_ASR = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] TYPE_RSV = TYPE_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [TYPE_W-1:0]  r_type;
  logic [AMT_W-1:0]   r_amount;
  logic [AMT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   r_result;
  logic               r_done;
  logic               r_err;

  logic               w_accept;
  logic               w_count_dec;
  logic               w_capture;
  logic               w_skip_shift;
  logic [OP_W-1:0]    w_shift_op;

  // Shift op issued in SHIFT, selected by the latched request type
  always_comb begin
    w_shift_op = OP_NOP;
    case (r_type)
      TYPE_LSL: w_shift_op = OP_LSL;
      TYPE_LSR: w_shift_op = OP_LSR;
      TYPE_ASR: w_shift_op = OP_ASR;
      default:  w_shift_op = OP_NOP;
    endcase
  end

  // A zero amount or the reserved type passes the loaded operand straight to CAPTURE
  assign w_skip_shift = (r_amount == AMT_W'(0)) || (r_type == TYPE_RSV);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus Moore decode of sh_op/busy and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    sh_op       = OP_NOP;
    busy        = 1'b1;
    w_accept    = 1'b0;
    w_count_dec = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sh_op = OP_LOAD;
        if (w_skip_shift) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sh_op = w_shift_op;
        // Counter is at least 1 on entry; guard keeps it from wrapping
        if (r_count != AMT_W'(0)) begin
          w_count_dec = 1'b1;
        end
        if (r_count <= AMT_W'(1)) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        sh_op       = OP_NOP;
        w_capture   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request latch, step counter, result capture and completion flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_type   <= TYPE_W'(0);
      r_amount <= AMT_W'(0);
      r_count  <= AMT_W'(0);
      r_data   <= WIDTH'(0);
      r_result <= WIDTH'(0);
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_type   <= shift_type;
        r_amount <= amount;
        r_data   <= data_in;
        r_count  <= amount;
      end else if (w_count_dec) begin
        r_count <= r_count - AMT_W'(1);
      end
      if (w_capture) begin
        r_result <= sh_q;
      end
      r_done <= w_capture;
      r_err  <= w_capture && (r_type == TYPE_RSV);
    end
  end

  assign sh_d_in = r_data;
  assign result  = r_result;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks of shift_sequencer driving a
// behavioural shifter32 model whose output feeds back into sh_q.

module tb_shift_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  shift_type;
  logic [4:0]  amount;
  logic [31:0] data_in;
  logic [2:0]  sh_op;
  logic [31:0] sh_d_in;
  logic [31:0] sh_q;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;

  int          n_checks;
  int          n_errors;
  int          cyc;
  int          n_shift_ops;
  logic [2:0]  op_log [0:63];

  shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .shift_type (shift_type),
    .amount     (amount),
    .data_in    (data_in),
    .sh_op      (sh_op),
    .sh_d_in    (sh_d_in),
    .sh_q       (sh_q),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result)
  );

  // Behavioural shifter32: one-bit step per cycle, shares reset_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q <= 32'h0;
    end else begin
      case (sh_op)
        3'b001:  sh_q <= sh_d_in;
        3'b010:  sh_q <= {sh_q[30:0], 1'b0};
        3'b011:  sh_q <= {1'b0, sh_q[31:1]};
        3'b100:  sh_q <= {sh_q[31], sh_q[31:1]};
        default: sh_q <= sh_q;
      endcase
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request for one edge; afterwards we sit in cycle 1
  task automatic issue(input logic [1:0] t, input logic [4:0] a, input logic [31:0] d);
    start      = 1'b1;
    shift_type = t;
    amount     = a;
    data_in    = d;
    @(posedge clk);
    #1;
    start       = 1'b0;
    cyc         = 1;
    n_shift_ops = 0;
  endtask

  // Log the current op and advance one cycle
  task automatic step();
    if (cyc < 64) op_log[cyc] = sh_op;
    if (sh_op == 3'b010 || sh_op == 3'b011 || sh_op == 3'b100) n_shift_ops++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Run to the done pulse (bounded) and check latency, result and err
  task automatic finish_op(input string tag, input int exp_cyc, input int exp_shifts,
                           input logic [31:0] exp_res, input logic exp_err);
    while (!done && cyc < 80) step();
    check({tag, "_done_seen"}, 32'(done), 32'h1);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_shift_count"}, 32'(n_shift_ops), 32'(exp_shifts));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_busy_in_done"}, 32'(busy), 32'h0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    shift_type = 2'b00;
    amount     = 5'd0;
    data_in    = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_sh_op", 32'(sh_op), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_sh_d_in", sh_d_in, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // LSL 4 of 0xF1, with an ignored start in the middle of SHIFT
    issue(2'b00, 5'd4, 32'h0000_00F1);
    check("lsl_busy_c1", 32'(busy), 32'h1);
    check("lsl_d_in_c1", sh_d_in, 32'h0000_00F1);
    step();
    step();
    start      = 1'b1;
    shift_type = 2'b01;
    amount     = 5'd7;
    data_in    = 32'hFFFF_FFFF;
    step();
    start = 1'b0;
    check("lsl_d_in_after_ignored_start", sh_d_in, 32'h0000_00F1);
    finish_op("lsl4", 7, 4, 32'h0000_0F10, 1'b0);
    check("lsl_op_c1", 32'(op_log[1]), 32'h1);
    check("lsl_op_c2", 32'(op_log[2]), 32'h2);
    check("lsl_op_c5", 32'(op_log[5]), 32'h2);
    check("lsl_op_c6", 32'(op_log[6]), 32'h0);

    // New request accepted in the done cycle
    issue(2'b00, 5'd1, 32'h0000_0001);
    finish_op("b2b_lsl1", 4, 1, 32'h0000_0002, 1'b0);
    step();
    check("done_one_cycle", 32'(done), 32'h0);

    // ASR 8 replicates the sign bit
    issue(2'b10, 5'd8, 32'h8000_0000);
    finish_op("asr8", 11, 8, 32'hFF80_0000, 1'b0);
    step();

    // LSR by the maximum amount
    issue(2'b01, 5'd31, 32'hFFFF_FFFF);
    finish_op("lsr31", 34, 31, 32'h0000_0001, 1'b0);
    step();

    // Zero amount: operand passes through
    issue(2'b01, 5'd0, 32'h1234_5678);
    finish_op("amt0", 3, 0, 32'h1234_5678, 1'b0);
    step();

    // Reserved type: pass-through with err
    issue(2'b11, 5'd5, 32'hA5A5_A5A5);
    finish_op("rsv", 3, 0, 32'hA5A5_A5A5, 1'b1);
    step();
    check("err_one_cycle", 32'(err), 32'h0);

    // Reset asserted in cycle 3 of an amount=10 request
    issue(2'b00, 5'd10, 32'h0000_0003);
    step();
    step();
    check("mid_shift_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("abort_sh_op", 32'(sh_op), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_result", result, 32'h0);
    check("abort_done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    begin
      int done_seen;
      done_seen = 0;
      for (int i = 0; i < 14; i++) begin
        @(posedge clk);
        #1;
        if (done) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'h0);
    end
    check("abort_idle_busy", 32'(busy), 32'h0);

    // Normal request after the abort
    issue(2'b01, 5'd3, 32'h0000_00F0);
    finish_op("post_rst_lsr3", 6, 3, 32'h0000_001E, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
